// File: rtl/lut_fractured_scan.sv
// Purpose : fractured LUT with a chainable bit-serial config scan path and a shadow/active truth table.
// Latency : out follows addr combinationally (REGISTERED_OUT=0) or one config_clk later (REGISTERED_OUT=1).
// Backpr. : none; the shift is always accepted, and a commit while not full is dropped and flagged in config_err.
module lut_fractured_scan #(
    parameter int INPUTS         = 4,
    parameter int FRACTURING     = 1,
    parameter int CFG_WIDTH      = 1,
    parameter int REGISTERED_OUT = 0
) (
    input  logic                        config_clk,
    input  logic                        config_rst_n,
    input  logic [INPUTS-1:0]           addr,
    output logic [(2**FRACTURING):0]    out,
    input  logic                        config_en,
    input  logic [CFG_WIDTH-1:0]        config_in,
    output logic [CFG_WIDTH-1:0]        config_out,
    input  logic                        config_commit,
    output logic                        config_full,
    output logic                        config_valid,
    output logic                        config_err
);

    localparam int MEM_SIZE = 1 << INPUTS;
    localparam int WORDS    = MEM_SIZE / CFG_WIDTH;
    localparam int NSUB     = 1 << FRACTURING;
    localparam int SUBW     = INPUTS - FRACTURING;
    localparam int CNT_W    = $clog2(WORDS + 1);

    localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);

    // Control states; the state always tracks the saturating word counter.
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_FILLING = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Stop elaboration on a fracture depth or scan width the table cannot support.
    generate
        if (FRACTURING < 0 || FRACTURING >= INPUTS || CFG_WIDTH < 1 ||
            (MEM_SIZE % CFG_WIDTH) != 0) begin : g_param_check
            $error("lut_fractured_scan: illegal INPUTS/FRACTURING/CFG_WIDTH combination");
        end
    endgenerate

    logic [MEM_SIZE-1:0] shadow_q, shadow_d;
    logic [MEM_SIZE-1:0] active_q, active_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [1:0]          state_q, state_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                commit_ok;
    logic [NSUB:0]       eval;

    // Shadow scan shift: new words enter at the top, so the first word sent ends up at the bottom.
    generate
        if (CFG_WIDTH == MEM_SIZE) begin : g_shift_whole
            always_comb begin
                shadow_d = shadow_q;
                if (config_en) begin
                    shadow_d = config_in;
                end
            end
        end else begin : g_shift_part
            always_comb begin
                shadow_d = shadow_q;
                if (config_en) begin
                    shadow_d = {config_in, shadow_q[MEM_SIZE-1:CFG_WIDTH]};
                end
            end
        end
    endgenerate

    // Commit, counter and flag next-state; a commit is honoured only when the shadow holds a full table.
    always_comb begin
        commit_ok = config_commit && (count_q == WORDS_C);
        count_d   = count_q;
        active_d  = active_q;
        valid_d   = valid_q;
        err_d     = err_q;
        if (commit_ok) begin
            active_d = shadow_q;
            valid_d  = 1'b1;
            err_d    = 1'b0;
            count_d  = config_en ? CNT_W'(1) : '0;
        end else begin
            if (config_commit) begin
                err_d = 1'b1;
            end
            if (config_en && (count_q != WORDS_C)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (count_d == '0) begin
            state_d = ST_EMPTY;
        end else if (count_d == WORDS_C) begin
            state_d = ST_FULL;
        end else begin
            state_d = ST_FILLING;
        end
    end

    // Configuration and control registers.
    always_ff @(posedge config_clk or negedge config_rst_n) begin
        if (!config_rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            state_q  <= ST_EMPTY;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            state_q  <= state_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Table lookup from the active copy only; sub-LUT k covers the k-th slice of S entries.
    always_comb begin
        logic [INPUTS-1:0] idx;
        eval = '0;
        idx  = '0;
        if (valid_q) begin
            eval[0] = active_q[addr];
            for (int k = 0; k < NSUB; k++) begin
                idx            = INPUTS'(k) << SUBW;
                idx[SUBW-1:0]  = addr[SUBW-1:0];
                eval[k+1]      = active_q[idx];
            end
        end
    end

    generate
        if (REGISTERED_OUT != 0) begin : g_out_reg
            logic [NSUB:0] out_q;
            // Optional output pipeline stage on the config clock.
            always_ff @(posedge config_clk or negedge config_rst_n) begin
                if (!config_rst_n) begin
                    out_q <= '0;
                end else begin
                    out_q <= eval;
                end
            end
            assign out = out_q;
        end else begin : g_out_comb
            assign out = eval;
        end
    endgenerate

    assign config_out   = shadow_q[CFG_WIDTH-1:0];
    assign config_full  = (state_q == ST_FULL);
    assign config_valid = valid_q;
    assign config_err   = err_q;

endmodule

// File: tb/tb_lut_fractured_scan.sv
module tb_lut_fractured_scan;

    logic config_clk = 1'b0;
    always #5 config_clk = ~config_clk;

    logic       rst_n;
    logic [3:0] addr_a, addr_b, addr_c;
    logic       en, cin, commit;
    logic       en_c, commit_c;
    logic [3:0] cin_c;

    logic [2:0] out_a, out_b, out_c;
    logic       co_a, co_b;
    logic [3:0] co_c;
    logic       full_a, full_b, full_c;
    logic       valid_a, valid_b, valid_c;
    logic       err_a, err_b, err_c;

    // Upstream instance of the chain.
    lut_fractured_scan #(.INPUTS(4), .FRACTURING(1), .CFG_WIDTH(1), .REGISTERED_OUT(0)) u_a (
        .config_clk(config_clk), .config_rst_n(rst_n), .addr(addr_a), .out(out_a),
        .config_en(en), .config_in(cin), .config_out(co_a), .config_commit(commit),
        .config_full(full_a), .config_valid(valid_a), .config_err(err_a));

    // Downstream instance fed by the upstream scan output.
    lut_fractured_scan #(.INPUTS(4), .FRACTURING(1), .CFG_WIDTH(1), .REGISTERED_OUT(0)) u_b (
        .config_clk(config_clk), .config_rst_n(rst_n), .addr(addr_b), .out(out_b),
        .config_en(en), .config_in(co_a), .config_out(co_b), .config_commit(commit),
        .config_full(full_b), .config_valid(valid_b), .config_err(err_b));

    // Nibble-wide scan with registered output.
    lut_fractured_scan #(.INPUTS(4), .FRACTURING(1), .CFG_WIDTH(4), .REGISTERED_OUT(1)) u_c (
        .config_clk(config_clk), .config_rst_n(rst_n), .addr(addr_c), .out(out_c),
        .config_en(en_c), .config_in(cin_c), .config_out(co_c), .config_commit(commit_c),
        .config_full(full_c), .config_valid(valid_c), .config_err(err_c));

    // Reference model: whole tables as 16-bit integers, one slot per instance.
    logic [15:0] m_sh  [3];
    logic [15:0] m_act [3];
    int          m_cnt [3];
    logic        m_val [3];
    logic        m_err [3];
    logic [2:0]  m_outc;

    int n_assert = 0;
    int n_fail   = 0;

    function automatic int cw_of(input int i);
        return (i == 2) ? 4 : 1;
    endfunction

    function automatic int words_of(input int i);
        return 16 / cw_of(i);
    endfunction

    // out[0]: bit a of the table; out[1]/out[2]: bit (a mod 8) of the low/high half.
    function automatic logic [2:0] exp_out(input logic [15:0] act, input logic val, input int a);
        logic [2:0] r;
        int lo;
        r  = '0;
        lo = a % 8;
        if (val) begin
            r[0] = ((act >> a) & 16'd1) != 16'd0;
            r[1] = ((act >> lo) & 16'd1) != 16'd0;
            r[2] = ((act >> (8 + lo)) & 16'd1) != 16'd0;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int i = 0; i < 3; i++) begin
            m_sh[i]  = '0;
            m_act[i] = '0;
            m_cnt[i] = 0;
            m_val[i] = 1'b0;
            m_err[i] = 1'b0;
        end
        m_outc = '0;
    endtask

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic mdl_edge();
        logic [15:0] win [3];
        logic        e   [3];
        logic        c   [3];
        logic [15:0] nsh;
        int          w;
        win[0] = {15'b0, cin};
        win[1] = {15'b0, m_sh[0][0]};
        win[2] = {12'b0, cin_c};
        e[0] = en;     e[1] = en;     e[2] = en_c;
        c[0] = commit; c[1] = commit; c[2] = commit_c;
        m_outc = exp_out(m_act[2], m_val[2], int'(addr_c));
        for (int i = 0; i < 3; i++) begin
            w   = words_of(i);
            nsh = e[i] ? ((m_sh[i] >> cw_of(i)) | (win[i] << (16 - cw_of(i)))) : m_sh[i];
            if (c[i] && m_cnt[i] == w) begin
                m_act[i] = m_sh[i];
                m_val[i] = 1'b1;
                m_err[i] = 1'b0;
                m_cnt[i] = e[i] ? 1 : 0;
            end else begin
                if (c[i]) m_err[i] = 1'b1;
                if (e[i] && m_cnt[i] < w) m_cnt[i]++;
            end
            m_sh[i] = nsh;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_a_out"},   16'(out_a),   16'(exp_out(m_act[0], m_val[0], int'(addr_a))));
        chk({tag, "_a_cout"},  16'(co_a),    16'(m_sh[0][0]));
        chk({tag, "_a_full"},  16'(full_a),  16'(m_cnt[0] == 16));
        chk({tag, "_a_valid"}, 16'(valid_a), 16'(m_val[0]));
        chk({tag, "_a_err"},   16'(err_a),   16'(m_err[0]));
        chk({tag, "_b_out"},   16'(out_b),   16'(exp_out(m_act[1], m_val[1], int'(addr_b))));
        chk({tag, "_b_cout"},  16'(co_b),    16'(m_sh[1][0]));
        chk({tag, "_b_full"},  16'(full_b),  16'(m_cnt[1] == 16));
        chk({tag, "_b_valid"}, 16'(valid_b), 16'(m_val[1]));
        chk({tag, "_b_err"},   16'(err_b),   16'(m_err[1]));
        chk({tag, "_c_out"},   16'(out_c),   16'(m_outc));
        chk({tag, "_c_cout"},  16'(co_c),    16'(m_sh[2][3:0]));
        chk({tag, "_c_full"},  16'(full_c),  16'(m_cnt[2] == 4));
        chk({tag, "_c_valid"}, 16'(valid_c), 16'(m_val[2]));
        chk({tag, "_c_err"},   16'(err_c),   16'(m_err[2]));
    endtask

    task automatic tick(input string tag);
        mdl_edge();
        @(posedge config_clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle_inputs();
        en = 1'b0; cin = 1'b0; commit = 1'b0;
        en_c = 1'b0; cin_c = '0; commit_c = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        mdl_reset();
        #1;
        check_all("rst");
        rst_n = 1'b1;
    endtask

    // Shift a 16-bit table into the A/B chain LSB-first.
    task automatic shift_ab(input logic [15:0] w, input string tag);
        for (int b = 0; b < 16; b++) begin
            en  = 1'b1;
            cin = w[b];
            tick(tag);
        end
        en = 1'b0;
    endtask

    task automatic commit_ab(input string tag);
        commit = 1'b1;
        tick(tag);
        commit = 1'b0;
    endtask

    initial begin
        logic [15:0] va, vb, w;
        rst_n  = 1'b0;
        addr_a = '0; addr_b = '0; addr_c = '0;
        idle_inputs();
        mdl_reset();
        @(posedge config_clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // 1: load A5C3, commit, look at address 1010
        w = 16'hA5C3;
        for (int b = 0; b < 16; b++) begin
            en  = 1'b1;
            cin = w[b];
            tick("t1");
            if (b == 14) chk("t1_full_at15", 16'(full_a), 16'd0);
        end
        en = 1'b0;
        chk("t1_full_at16", 16'(full_a), 16'd1);
        commit_ab("t1c");
        addr_a = 4'b1010;
        #1;
        chk("t1_valid", 16'(valid_a), 16'd1);
        chk("t1_out", 16'(out_a), 16'h0005);

        // 2: early commit is rejected, completed commit clears the error
        do_reset();
        for (int b = 0; b < 10; b++) begin
            en = 1'b1; cin = 1'($urandom); tick("t2s");
        end
        en = 1'b0;
        commit_ab("t2e");
        chk("t2_err", 16'(err_a), 16'd1);
        chk("t2_novalid", 16'(valid_a), 16'd0);
        chk("t2_out0", 16'(out_a), 16'd0);
        for (int b = 0; b < 6; b++) begin
            en = 1'b1; cin = 1'($urandom); tick("t2f");
        end
        en = 1'b0;
        commit_ab("t2c");
        chk("t2_errclr", 16'(err_a), 16'd0);
        chk("t2_valid", 16'(valid_a), 16'd1);

        // 3: 32-bit chain load
        do_reset();
        shift_ab(16'hFFFF, "t3a");
        shift_ab(16'h1234, "t3b");
        chk("t3_full_up", 16'(full_a), 16'd1);
        chk("t3_full_dn", 16'(full_b), 16'd1);
        commit_ab("t3c");
        va = '0; vb = '0;
        for (int a = 0; a < 16; a++) begin
            addr_a = 4'(a); addr_b = 4'(a);
            #1;
            va[a] = out_a[0];
            vb[a] = out_b[0];
        end
        chk("t3_up_table", va, 16'h1234);
        chk("t3_dn_table", vb, 16'hFFFF);

        // 4: active table holds while the shadow reloads; shift+commit leaves count at 1
        do_reset();
        shift_ab(16'h00FF, "t4l");
        commit_ab("t4c");
        addr_a = 4'd3;
        #1;
        chk("t4_before", 16'(out_a[0]), 16'd1);
        for (int b = 0; b < 16; b++) begin
            en = 1'b1; cin = 1'b0; tick("t4s");
            chk("t4_hold", 16'(out_a[0]), 16'd1);
        end
        en = 1'b1; cin = 1'b0; commit = 1'b1;
        tick("t4x");
        commit = 1'b0;
        chk("t4_after", 16'(out_a[0]), 16'd0);
        chk("t4_cnt1_notfull", 16'(full_a), 16'd0);
        for (int b = 0; b < 15; b++) begin
            en = 1'b1; cin = 1'b0; tick("t4r");
            if (b == 13) chk("t4_full_at14", 16'(full_a), 16'd0);
        end
        en = 1'b0;
        chk("t4_full_at15", 16'(full_a), 16'd1);

        // 5: nibble scan with registered output
        do_reset();
        addr_c = 4'd5;
        w = 16'h8001;
        for (int b = 0; b < 4; b++) begin
            en_c = 1'b1; cin_c = w[4*b +: 4]; tick("t5s");
        end
        en_c = 1'b0;
        chk("t5_full", 16'(full_c), 16'd1);
        commit_c = 1'b1; tick("t5c"); commit_c = 1'b0;
        tick("t5w");
        chk("t5_addr5", 16'(out_c[0]), 16'd0);
        addr_c = 4'd15;
        #1;
        chk("t5_not_yet", 16'(out_c[0]), 16'd0);
        tick("t5r");
        chk("t5_out15", 16'(out_c[0]), 16'd1);

        // 6: asynchronous reset in the middle of a reload
        do_reset();
        shift_ab(16'hA5C3, "t6l");
        commit_ab("t6c");
        addr_a = 4'b1010;
        for (int b = 0; b < 8; b++) begin
            en = 1'b1; cin = 1'($urandom); tick("t6s");
        end
        en = 1'b0;
        #1;
        chk("t6_pre_out", 16'(out_a), 16'h0005);
        rst_n = 1'b0;
        mdl_reset();
        #1;
        chk("t6_async_out", 16'(out_a), 16'd0);
        chk("t6_async_valid", 16'(valid_a), 16'd0);
        chk("t6_async_full", 16'(full_a), 16'd0);
        check_all("t6r");
        rst_n = 1'b1;
        for (int b = 0; b < 15; b++) begin
            en = 1'b1; cin = 1'b1; tick("t6p");
        end
        en = 1'b0;
        commit_ab("t6e");
        chk("t6_partial_err", 16'(err_a), 16'd1);
        chk("t6_partial_novalid", 16'(valid_a), 16'd0);
        en = 1'b1; cin = 1'b1; tick("t6q"); en = 1'b0;
        commit_ab("t6ok");
        chk("t6_reload_valid", 16'(valid_a), 16'd1);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 600; n++) begin
            en       = ($urandom_range(0, 9) < 8);
            cin      = 1'($urandom);
            commit   = ($urandom_range(0, 14) == 0);
            addr_a   = 4'($urandom);
            addr_b   = 4'($urandom);
            en_c     = ($urandom_range(0, 9) < 6);
            cin_c    = 4'($urandom);
            commit_c = ($urandom_range(0, 5) == 0);
            addr_c   = 4'($urandom);
            tick("rnd");
            if ($urandom_range(0, 249) == 0) do_reset();
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
